// File: rtl/host_fifo_packer_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | host_fifo_packer_if                                                      |
// | Byte-stream input and host FIFO frame output bundle for host_fifo_packer.|
// |   in_data/in_valid/in_ready  : byte stream from the IP core             |
// |   flush                      : single-cycle drain request               |
// |   out_cnt/out_data/out_valid/out_ready : host FIFO frame write port     |
// |   level                      : bytes currently buffered                 |
// | Modports: slave = packer side, master = IP/host (driver) side.           |
// | Revision: 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
interface host_fifo_packer_if;
   logic [7:0]   in_data;
   logic         in_valid;
   logic         in_ready;
   logic         flush;
   logic [2:0]   out_cnt;
   logic [127:0] out_data;
   logic         out_valid;
   logic         out_ready;
   logic [4:0]   level;

   modport slave (
      input  in_data, in_valid, flush, out_ready,
      output in_ready, out_cnt, out_data, out_valid, level
   );

   modport master (
      output in_data, in_valid, flush, out_ready,
      input  in_ready, out_cnt, out_data, out_valid, level
   );
endinterface
`default_nettype wire

// File: rtl/host_fifo_packer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | host_fifo_packer                                                         |
// | Packs an IP byte stream into host FIFO frames (count code + up to 16     |
// | payload bytes, code set D0 D1 D2 D4 D5 D6 D8 D16). A frame is emitted    |
// | when the staging buffer is full, on flush, or optionally on idle timeout.|
// | Ports:                                                                   |
// |   clk  : sole clock, rising edge                                         |
// |   rst  : asynchronous active-high reset                                  |
// |   bus  : host_fifo_packer_if.slave (byte input, frame output, level)     |
// | Parameters:                                                              |
// |   MAX_PAYLOAD : frame size limit, one of 1, 2, 4, 5, 6, 8, 16            |
// |   TIMEOUT     : idle cycles before automatic flush (2..65535), present   |
// |                 only when HOST_FIFO_PACKER_TIMEOUT_EN is defined         |
// | Macro HOST_FIFO_PACKER_TIMEOUT_EN enables the idle-timeout flush.        |
// | Revision: 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
module host_fifo_packer #(
   parameter int MAX_PAYLOAD = 16
`ifdef HOST_FIFO_PACKER_TIMEOUT_EN
   ,parameter int TIMEOUT    = 64
`endif
) (
   input wire               clk,
   input wire               rst,
   host_fifo_packer_if.slave bus
);

   localparam logic [0:0] c_fill = 1'b0;
   localparam logic [0:0] c_emit = 1'b1;
   localparam logic [4:0] c_max  = 5'(MAX_PAYLOAD);

   logic [0:0]               r_state;
   logic [0:0]               w_state_next;
   logic [MAX_PAYLOAD*8-1:0] r_buf;
   logic [MAX_PAYLOAD*8-1:0] w_buf_next;
   logic [4:0]               r_level;
   logic [4:0]               w_level_next;
   logic                     r_flush_pend;
   logic                     w_pend_next;
   logic [2:0]               r_code;
   logic [4:0]               w_payload;
   logic                     w_accept;
   logic                     w_fire;
   logic                     w_timeout;

   // Largest legal code whose payload fits in n bytes.
   function automatic logic [2:0] code_of(input logic [4:0] n);
      if (n >= 5'd16)     return 3'd7;
      else if (n >= 5'd8) return 3'd6;
      else if (n >= 5'd6) return 3'd5;
      else if (n >= 5'd5) return 3'd4;
      else if (n >= 5'd4) return 3'd3;
      else if (n >= 5'd2) return 3'd2;
      else if (n >= 5'd1) return 3'd1;
      else                return 3'd0;
   endfunction

   function automatic logic [4:0] payload_of(input logic [2:0] c);
      case (c)
         3'd1:    return 5'd1;
         3'd2:    return 5'd2;
         3'd3:    return 5'd4;
         3'd4:    return 5'd5;
         3'd5:    return 5'd6;
         3'd6:    return 5'd8;
         3'd7:    return 5'd16;
         default: return 5'd0;
      endcase
   endfunction

   // Datapath next-state: byte write, post-emit shift, level and flush flag.
   always_comb begin
      w_accept     = (r_state == c_fill) && bus.in_valid && (r_level < c_max);
      w_fire       = (r_state == c_emit) && bus.out_ready;
      w_payload    = payload_of(r_code);
      w_buf_next   = r_buf;
      w_level_next = r_level;
      w_pend_next  = r_flush_pend | bus.flush | w_timeout;
      if (w_accept) begin
         for (int i = 0; i < MAX_PAYLOAD; i++) begin
            if (r_level == 5'(i)) w_buf_next[i*8 +: 8] = bus.in_data;
         end
         w_level_next = r_level + 5'd1;
      end
      if (w_fire) begin
         // Unsent bytes slide down so the oldest is always at index 0.
         w_buf_next   = r_buf >> {w_payload, 3'b000};
         w_level_next = r_level - w_payload;
      end
      // A drain request with nothing left to drain is dropped, so no D0 frame.
      if (w_level_next == 5'd0) w_pend_next = 1'b0;
   end

`ifdef HOST_FIFO_PACKER_TIMEOUT_EN
   logic [15:0] r_idle;

   always_comb begin
      w_timeout = (r_state == c_fill) && (r_level != 5'd0) && !w_accept &&
                  (r_idle == 16'(TIMEOUT - 1));
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_idle <= '0;
      end else if ((r_state != c_fill) || w_accept || (r_level == 5'd0) || w_timeout) begin
         r_idle <= '0;
      end else begin
         r_idle <= r_idle + 16'd1;
      end
   end
`else
   assign w_timeout = 1'b0;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_buf        <= '0;
         r_level      <= '0;
         r_flush_pend <= 1'b0;
         r_code       <= 3'd0;
      end else begin
         r_buf        <= w_buf_next;
         r_level      <= w_level_next;
         r_flush_pend <= w_pend_next;
         r_code       <= code_of(w_level_next);
      end
   end

   // FSM state register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= c_fill;
      else     r_state <= w_state_next;
   end

   // FSM next-state
   always_comb begin
      w_state_next = r_state;
      case (r_state)
         c_fill: begin
            if ((w_level_next == c_max) || (w_pend_next && (w_level_next != 5'd0)))
               w_state_next = c_emit;
         end
         c_emit: begin
            if (w_fire && !(w_pend_next && (w_level_next != 5'd0)))
               w_state_next = c_fill;
         end
         default: w_state_next = c_fill;
      endcase
   end

   // FSM outputs; payload is masked so bytes beyond the frame read as zero.
   always_comb begin
      bus.in_ready  = (r_state == c_fill) && (r_level < c_max);
      bus.out_valid = (r_state == c_emit);
      bus.out_cnt   = 3'd0;
      bus.out_data  = '0;
      bus.level     = r_level;
      if (r_state == c_emit) begin
         bus.out_cnt = r_code;
         for (int i = 0; i < MAX_PAYLOAD; i++) begin
            if (5'(i) < w_payload) bus.out_data[i*8 +: 8] = r_buf[i*8 +: 8];
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_host_fifo_packer.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_host_fifo_packer                                                      |
// | Self-checking bench: directed scenarios plus random traffic against a    |
// | queue-based reference model (dut_a, MAX_PAYLOAD=16), and a directed      |
// | MAX_PAYLOAD=8 run on dut_b.                                              |
// | Revision: 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
module tb_host_fifo_packer;
   localparam int MAXA = 16;
   localparam int MAXB = 8;
`ifdef HOST_FIFO_PACKER_TIMEOUT_EN
   localparam int TMO = 64;
`endif

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   host_fifo_packer_if bus_a();
   host_fifo_packer_if bus_b();

   host_fifo_packer #(.MAX_PAYLOAD(MAXA)) dut_a (.clk(clk), .rst(rst), .bus(bus_a));
   host_fifo_packer #(.MAX_PAYLOAD(MAXB)) dut_b (.clk(clk), .rst(rst), .bus(bus_b));

   int tests = 0;
   int fails = 0;

   // Reference model state: bytes held, emitting flag, pending drain, idle count
   logic [7:0] mq[$];
   bit         memit;
   bit         mpend;
   int         midle;
   int         code_sizes [8] = '{0, 1, 2, 4, 5, 6, 8, 16};
   int         nb;

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic int code_of(input int n);
      int c = 0;
      for (int k = 0; k < 8; k++) if (code_sizes[k] <= n) c = k;
      return c;
   endfunction

   function automatic logic [127:0] exp_data();
      logic [127:0] d = '0;
      if (memit) begin
         for (int k = 0; k < code_sizes[code_of(mq.size())]; k++) d[k*8 +: 8] = mq[k];
      end
      return d;
   endfunction

   task automatic model_reset();
      mq.delete();
      memit = 0;
      mpend = 0;
      midle = 0;
   endtask

   task automatic model_step();
      bit pend;
      bit acc;
      bit tmo;
      int n;
      tmo = 0;
      if (!memit) begin
         acc = bus_a.in_valid && (mq.size() < MAXA);
`ifdef HOST_FIFO_PACKER_TIMEOUT_EN
         if (mq.size() == 0 || acc) midle = 0;
         else begin
            midle++;
            if (midle == TMO) begin tmo = 1; midle = 0; end
         end
`endif
         if (acc) mq.push_back(bus_a.in_data);
         pend = mpend || bus_a.flush || tmo;
         if (mq.size() == 0) pend = 0;
         memit = (mq.size() == MAXA) || pend;
         mpend = pend;
      end else begin
         midle = 0;
         pend = mpend || bus_a.flush;
         if (bus_a.out_ready) begin
            n = code_sizes[code_of(mq.size())];
            repeat (n) void'(mq.pop_front());
            if (!(pend && mq.size() > 0)) begin memit = 0; pend = 0; end
         end
         mpend = pend;
      end
   endtask

   // One cycle on dut_a: compare against model mid-cycle, advance model.
   task automatic tick();
      @(negedge clk);
      chk("a_in_ready",  128'(bus_a.in_ready),  128'(!memit && mq.size() < MAXA));
      chk("a_out_valid", 128'(bus_a.out_valid), 128'(memit));
      chk("a_out_cnt",   128'(bus_a.out_cnt),   memit ? 128'(code_of(mq.size())) : 128'd0);
      chk("a_out_data",  bus_a.out_data,        exp_data());
      chk("a_level",     128'(bus_a.level),     128'(mq.size()));
      model_step();
      @(posedge clk); #1;
   endtask

   // One cycle on dut_b, checking any frame against the 0x30.. byte sequence.
   task automatic b_cycle();
      logic [127:0] ed;
      int n;
      @(negedge clk);
      if (bus_b.out_valid) begin
         n  = (nb < 2) ? 8 : 4;
         ed = '0;
         for (int k = 0; k < n; k++) ed[k*8 +: 8] = 8'(8'h30 + nb*8 + k);
         chk("b_out_cnt",  128'(bus_b.out_cnt), (nb < 2) ? 128'd6 : 128'd3);
         chk("b_out_data", bus_b.out_data, ed);
         nb++;
      end
      @(posedge clk); #1;
   endtask

   initial begin
      logic [7:0]   bp_bytes [16];
      logic [127:0] ed;
      int           idle;
      int           k;
      int           guard;
      bit           acc;

      bus_a.in_data = '0; bus_a.in_valid = 0; bus_a.flush = 0; bus_a.out_ready = 0;
      bus_b.in_data = '0; bus_b.in_valid = 0; bus_b.flush = 0; bus_b.out_ready = 0;
      model_reset();
      nb  = 0;
      rst = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_in_ready",  128'(bus_a.in_ready),  128'd1);
      chk("rst_out_valid", 128'(bus_a.out_valid), 128'd0);
      chk("rst_out_cnt",   128'(bus_a.out_cnt),   128'd0);
      chk("rst_out_data",  bus_a.out_data,        128'd0);
      chk("rst_level",     128'(bus_a.level),     128'd0);
      @(posedge clk); #1;
      rst = 1'b0;

      // Full frame 0x00..0x0F
      bus_a.out_ready = 1;
      for (int i = 0; i < 16; i++) begin
         bus_a.in_valid = 1; bus_a.in_data = 8'(i);
         tick();
      end
      bus_a.in_valid = 0;
      chk("full_valid", 128'(bus_a.out_valid), 128'd1);
      chk("full_cnt",   128'(bus_a.out_cnt),   128'd7);
      chk("full_data",  bus_a.out_data, 128'h0F0E0D0C0B0A09080706050403020100);
      tick();
      tick();

      // Partial flush: 7 bytes then FLUSH -> D6 then D1
      for (int i = 0; i < 7; i++) begin
         bus_a.in_valid = 1; bus_a.in_data = 8'(8'hA0 + i);
         tick();
      end
      bus_a.in_valid = 0; bus_a.flush = 1;
      tick();
      bus_a.flush = 0;
      chk("pf_cnt0",  128'(bus_a.out_cnt), 128'd5);
      chk("pf_data0", bus_a.out_data,      128'h0000000000000000_0000A5A4A3A2A1A0);
      tick();
      chk("pf_cnt1",  128'(bus_a.out_cnt), 128'd1);
      chk("pf_data1", bus_a.out_data,      128'hA6);
      tick();
      chk("pf_ready", 128'(bus_a.in_ready), 128'd1);
      tick();

      // Idle behaviour with 3 bytes buffered
      for (int i = 0; i < 3; i++) begin
         bus_a.in_valid = 1; bus_a.in_data = 8'(8'h50 + i);
         tick();
      end
      bus_a.in_valid = 0;
`ifdef HOST_FIFO_PACKER_TIMEOUT_EN
      idle = 0;
      while (!bus_a.out_valid && idle < 200) begin
         tick();
         idle++;
      end
      chk("tmo_idle_cycles", 128'(idle), 128'(TMO));
      chk("tmo_cnt0", 128'(bus_a.out_cnt), 128'd2);
      tick();
      chk("tmo_cnt1", 128'(bus_a.out_cnt), 128'd1);
      tick();
`else
      repeat (80) tick();
      chk("notmo_valid", 128'(bus_a.out_valid), 128'd0);
      chk("notmo_level", 128'(bus_a.level),     128'd3);
      bus_a.flush = 1;
      tick();
      bus_a.flush = 0;
      repeat (3) tick();
`endif

      // Backpressure: full frame held for 10 cycles
      bus_a.out_ready = 0;
      ed = '0;
      for (int i = 0; i < 16; i++) begin
         bp_bytes[i] = 8'($urandom);
         ed[i*8 +: 8] = bp_bytes[i];
         bus_a.in_valid = 1; bus_a.in_data = bp_bytes[i];
         tick();
      end
      for (int i = 0; i < 10; i++) begin
         bus_a.in_data = 8'($urandom);
         chk("bp_valid", 128'(bus_a.out_valid), 128'd1);
         chk("bp_data",  bus_a.out_data,        ed);
         tick();
      end
      bus_a.in_valid = 0; bus_a.out_ready = 1;
      tick();
      tick();

      // Reset while a frame is pending
      for (int i = 0; i < 5; i++) begin
         bus_a.in_valid = 1; bus_a.in_data = 8'(8'hC0 + i);
         tick();
      end
      bus_a.in_valid = 0; bus_a.out_ready = 0; bus_a.flush = 1;
      tick();
      bus_a.flush = 0;
      tick();
      chk("rme_valid_before", 128'(bus_a.out_valid), 128'd1);
      rst = 1'b1;
      #1;
      chk("rme_out_valid", 128'(bus_a.out_valid), 128'd0);
      chk("rme_out_cnt",   128'(bus_a.out_cnt),   128'd0);
      chk("rme_out_data",  bus_a.out_data,        128'd0);
      chk("rme_level",     128'(bus_a.level),     128'd0);
      chk("rme_in_ready",  128'(bus_a.in_ready),  128'd1);
      model_reset();
      @(posedge clk); #1;
      rst = 1'b0;
      bus_a.out_ready = 1;
      repeat (4) tick();

      // Random traffic against the model
      for (int c = 0; c < 1500; c++) begin
         bus_a.in_valid  = ($urandom_range(0, 3) != 0);
         bus_a.in_data   = 8'($urandom);
         bus_a.flush     = ($urandom_range(0, 19) == 0);
         bus_a.out_ready = ($urandom_range(0, 3) != 0);
         tick();
      end
      bus_a.in_valid = 0; bus_a.flush = 1; bus_a.out_ready = 1;
      tick();
      bus_a.flush = 0;
      repeat (20) tick();

      // MAX_PAYLOAD=8: 20 bytes then FLUSH -> D8, D8, D4
      bus_b.out_ready = 1;
      k = 0; guard = 0;
      while (k < 20 && guard < 200) begin
         bus_b.in_valid = 1; bus_b.in_data = 8'(8'h30 + k);
         acc = 0;
         @(negedge clk);
         acc = bus_b.in_ready;
         if (bus_b.out_valid) begin
            ed = '0;
            for (int j = 0; j < 8; j++) ed[j*8 +: 8] = 8'(8'h30 + nb*8 + j);
            chk("b_out_cnt",  128'(bus_b.out_cnt), 128'd6);
            chk("b_out_data", bus_b.out_data, ed);
            nb++;
         end
         @(posedge clk); #1;
         if (acc) k++;
         guard++;
      end
      chk("b_bytes_sent", 128'(k), 128'd20);
      bus_b.in_valid = 0;
      b_cycle();
      chk("b_level_left", 128'(bus_b.level), 128'd4);
      bus_b.flush = 1;
      b_cycle();
      bus_b.flush = 0;
      repeat (4) b_cycle();
      bus_b.flush = 1;
      b_cycle();
      bus_b.flush = 0;
      repeat (8) b_cycle();
      chk("b_frames", 128'(nb), 128'd3);
      chk("b_level_end", 128'(bus_b.level), 128'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/host_fifo_packer.md
# host_fifo_packer

Packs a byte stream from an IP core into host FIFO frames. Each frame carries a 3-bit count code and up to 16 payload bytes, using the standard host FIFO code set (D0, D1, D2, D4, D5, D6, D8, D16). Frames are emitted when the payload limit is reached, on an explicit flush, or (optionally) after an idle timeout. The block sits between an IP's byte-wide output and the host FIFO write port, and generalises the fixed code/payload mapping into a buffering, parametrised framer.

## Interface
- MAX_PAYLOAD, 16: frame size limit in bytes; must be one of 1, 2, 4, 5, 6, 8, 16.
- TIMEOUT, 64: idle cycles before an automatic flush (only with the macro under Configuration); range 2..65535.
- CLK  in  1  sole clock; all logic on its rising edge.
- RESET  in  1  asynchronous, active-high reset.
- IN_DATA  in  8  byte from the IP.
- IN_VALID  in  1  IN_DATA valid.
- IN_READY  out  1  byte accepted when IN_VALID && IN_READY.
- FLUSH  in  1  single-cycle request to drain the buffer.
- OUT_CNT  out  3  count code: 000=D0, 001=D1, 010=D2, 011=D4, 100=D5, 101=D6, 110=D8, 111=D16.
- OUT_DATA  out  128  payload; first-received byte in [7:0]; bytes beyond the payload are zero.
- OUT_VALID  out  1  frame valid.
- OUT_READY  in  1  frame consumed when OUT_VALID && OUT_READY.
- LEVEL  out  5  bytes currently buffered (0..MAX_PAYLOAD).

## Operation
- Buffer: MAX_PAYLOAD-byte staging register, plus a level counter, a sticky flush_pend flag and a registered frame code.
- State FILL:
  - IN_READY = (LEVEL < MAX_PAYLOAD).
  - Each accepted byte is written at index LEVEL, then LEVEL increments.
  - Go to EMIT when LEVEL reaches MAX_PAYLOAD, or when flush_pend is set and LEVEL > 0.
- State EMIT:
  - IN_READY = 0 and OUT_VALID = 1.
  - OUT_CNT is the largest legal code whose payload is <= min(LEVEL, MAX_PAYLOAD).
  - Example: LEVEL 3 -> D2; 7 -> D6; 15 -> D8.
- On handshake:
  - Remaining bytes shift down to index 0 and LEVEL decreases by the payload.
  - If flush_pend is set and LEVEL > 0, stay in EMIT with the recomputed code.
  - Otherwise clear flush_pend and return to FILL.
- Flush requests:
  - FLUSH sets flush_pend in either state.
  - FLUSH with LEVEL == 0 in FILL is ignored; a D0 frame is never emitted.
- Simultaneous events:
  - FLUSH and an accepted byte in the same FILL cycle: the byte is included in the flush.
  - LEVEL reaching MAX_PAYLOAD and FLUSH in the same cycle: one D16 frame (or MAX_PAYLOAD frame), then flush_pend clears since LEVEL = 0.
- Output stability: OUT_CNT and OUT_DATA hold stable while OUT_VALID && !OUT_READY.
- Reset values, including reset asserted mid-frame: state FILL, LEVEL 0, flush_pend 0, OUT_VALID 0, OUT_CNT 000, OUT_DATA 0, IN_READY 1. Buffered bytes are discarded.

## Timing
- Input rate: one byte per cycle in FILL.
- Frame latency: the byte completing a full frame is accepted in cycle N; OUT_VALID is high in cycle N+1.
- Flush latency: FLUSH in cycle N (LEVEL > 0) gives OUT_VALID in cycle N+1.
- Back-to-back flush frames: with OUT_READY held high, one frame per cycle until drained; then FILL, with IN_READY high in the following cycle.
- LEVEL is registered and updates in the cycle after each accept or emit.

## Configuration
- HOST_FIFO_PACKER_TIMEOUT_EN defined:
  - An idle counter clears on every accepted byte and whenever LEVEL == 0.
  - It increments each FILL cycle with LEVEL > 0 and no accept.
  - On reaching TIMEOUT it sets flush_pend, with the same effect as FLUSH, and clears.
- Undefined:
  - No counter logic.
  - Frames are emitted only on a full buffer or FLUSH; bytes may remain buffered indefinitely.

## Test plan
- Full frame: 16 bytes 0x00..0x0F back-to-back, OUT_READY=1 -> OUT_VALID the cycle after the 16th byte, OUT_CNT=111, OUT_DATA=0x0F0E..0100, LEVEL returns to 0.
- Partial flush: 7 bytes 0xA0..0xA6, then FLUSH:
  - First frame: OUT_CNT=101, OUT_DATA[47:0]=0xA5A4A3A2A1A0, upper bits 0.
  - Next cycle: OUT_CNT=001, OUT_DATA[7:0]=0xA6.
  - Then FILL with IN_READY=1.
- Timeout (macro defined, TIMEOUT=64): 3 bytes, then idle -> OUT_CNT=010 after 64 idle cycles, then 001. No frame with the macro undefined.
- Backpressure: full frame with OUT_READY=0 for 10 cycles -> OUT_VALID, OUT_CNT and OUT_DATA stable; IN_READY=0 throughout; frame accepted on the first OUT_READY=1.
- Reset mid-EMIT: assert RESET while OUT_VALID=1 -> OUT_VALID, OUT_CNT, OUT_DATA and LEVEL all 0 and IN_READY=1 immediately (asynchronous); no stale frame after release.
- MAX_PAYLOAD=8: 20 bytes then FLUSH -> frames D8, D8, D4; the FLUSH with LEVEL=0 produces nothing further.
